bus0_xslv_arbiter: RTL and testbench

// - Shares one bus0 AXI4 slave port (e.g. CFG_BUS0_XSLV_DDR) among all bus0 masters (GROUP0 CPU, PCIE DMA).
// - Read and write channels are arbitrated independently: round-robin or fixed priority, one transaction in flight per direction.
// - Sits between the bus0 master vectors and a single slave's axi4_slave_in/out pair; instantiated once per contended slave.

---
 rtl/types_bus0_pkg.sv | 101 ++++++++++
 rtl/bus0_rr_pick.sv | 44 ++++
 rtl/bus0_xslv_arbiter.sv | 179 +++++++++++++++++
 tb/tb_bus0_xslv_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/types_bus0_pkg.sv
// Shared bus0 types: AXI4 channel bundles, master vectors, arbiter FSM
// state encodings and the grant index width.
// No ports (package).
package types_bus0_pkg;

  localparam int CFG_BUS0_XMST_GROUP0 = 0;
  localparam int CFG_BUS0_XMST_PCIE   = 1;
  localparam int CFG_BUS0_XMST_TOTAL  = 2;
  // Width of a master index; kept at least 1 so single-master builds still
  // have a legal vector.
  localparam int CFG_BUS0_XMST_LOG2_TOTAL =
    (CFG_BUS0_XMST_TOTAL > 1) ? $clog2(CFG_BUS0_XMST_TOTAL) : 1;

  localparam int CFG_BUS0_XSLV_DDR = 0;

  localparam int CFG_SYSBUS_ADDR_BITS  = 32;
  localparam int CFG_SYSBUS_DATA_BITS  = 64;
  localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;
  localparam int CFG_SYSBUS_ID_BITS    = 5;
  localparam int CFG_SYSBUS_USER_BITS  = 1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
    logic [7:0]                      len;
    logic [2:0]                      size;
    logic [1:0]                      burst;
    logic                            lock;
    logic [3:0]                      cache;
    logic [2:0]                      prot;
    logic [3:0]                      region;
    logic [3:0]                      qos;
  } axi4_metadata_type;

  typedef struct packed {
    logic                              aw_valid;
    axi4_metadata_type                 aw_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]     aw_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]   aw_user;
    logic                              w_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0]   w_data;
    logic                              w_last;
    logic [CFG_SYSBUS_DATA_BYTES-1:0]  w_strb;
    logic [CFG_SYSBUS_USER_BITS-1:0]   w_user;
    logic                              b_ready;
    logic                              ar_valid;
    axi4_metadata_type                 ar_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]     ar_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]   ar_user;
    logic                              r_ready;
  } axi4_master_out_type;

  typedef struct packed {
    logic                              aw_ready;
    logic                              w_ready;
    logic                              b_valid;
    logic [1:0]                        b_resp;
    logic [CFG_SYSBUS_ID_BITS-1:0]     b_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]   b_user;
    logic                              ar_ready;
    logic                              r_valid;
    logic [1:0]                        r_resp;
    logic [CFG_SYSBUS_DATA_BITS-1:0]   r_data;
    logic                              r_last;
    logic [CFG_SYSBUS_ID_BITS-1:0]     r_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]   r_user;
  } axi4_master_in_type;

  typedef axi4_master_out_type axi4_slave_in_type;
  typedef axi4_master_in_type  axi4_slave_out_type;

  typedef axi4_master_out_type [CFG_BUS0_XMST_TOTAL-1:0] bus0_xmst_out_vector;
  typedef axi4_master_in_type  [CFG_BUS0_XMST_TOTAL-1:0] bus0_xmst_in_vector;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } bus0_arb_rstate_type;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } bus0_arb_wstate_type;

  // Round-robin pointer advance: the master after idx, wrapping at nmst.
  function automatic logic [CFG_BUS0_XMST_LOG2_TOTAL-1:0] bus0_arb_next(
    input logic [CFG_BUS0_XMST_LOG2_TOTAL-1:0] idx,
    input int unsigned                         nmst
  );
    if (32'(idx) + 32'd1 >= nmst) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/bus0_rr_pick.sv
// Combinational arbiter pick: given a request vector and a round-robin
// pointer, returns the winning master as one-hot and as an index.
//   req  in  NMST  requesting masters
//   ptr  in  IW    first master considered (ignored when RR_EN=0)
//   gnt  out NMST  one-hot winner, 0 when no request
//   idx  out IW    winner index, 0 when no request
//   any  out 1     at least one request present
module bus0_rr_pick
  import types_bus0_pkg::*;
#(
  parameter int NMST  = CFG_BUS0_XMST_TOTAL,
  parameter bit RR_EN = 1'b1
) (
  input  logic [NMST-1:0]                     req,
  input  logic [CFG_BUS0_XMST_LOG2_TOTAL-1:0] ptr,
  output logic [NMST-1:0]                     gnt,
  output logic [CFG_BUS0_XMST_LOG2_TOTAL-1:0] idx,
  output logic                                any
);
  localparam int IW = CFG_BUS0_XMST_LOG2_TOTAL;

  logic [IW-1:0] start;
  logic [IW:0]   cand;

  // Scan NMST candidates starting at the pointer; fixed priority is the
  // same scan starting at master 0.
  always_comb begin
    start = RR_EN ? ptr : '0;
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NMST; k++) begin
      cand = {1'b0, start} + (IW+1)'(k);
      if (cand >= (IW+1)'(NMST)) cand = cand - (IW+1)'(NMST);
      if (!any && req[cand[IW-1:0]]) begin
        any = 1'b1;
        idx = cand[IW-1:0];
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/bus0_xslv_arbiter.sv
// Shares one bus0 AXI4 slave port among the bus0 masters. Read and write
// directions are arbitrated independently, one transaction in flight each.
//   i_clk     in   clock
//   i_nrst    in   async reset, active low
//   i_xmsto   in   master request bundles
//   o_xmsti   out  per-master responses (only the owner sees ready/valid)
//   o_xslvi   out  owner's request muxed to the slave
//   i_xslvo   in   slave response
//   o_rgrant  out  one-hot read owner, 0 when idle
//   o_wgrant  out  one-hot write owner, 0 when idle
// NMST must not exceed CFG_BUS0_XMST_TOTAL; extra vector entries are idle.
module bus0_xslv_arbiter
  import types_bus0_pkg::*;
#(
  parameter int NMST  = CFG_BUS0_XMST_TOTAL,
  parameter bit RR_EN = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  bus0_xmst_out_vector i_xmsto,
  output bus0_xmst_in_vector  o_xmsti,
  output axi4_slave_in_type   o_xslvi,
  input  axi4_slave_out_type  i_xslvo,
  output logic [NMST-1:0]     o_rgrant,
  output logic [NMST-1:0]     o_wgrant
);
  localparam int IW = CFG_BUS0_XMST_LOG2_TOTAL;

  bus0_arb_rstate_type r_state;
  bus0_arb_wstate_type w_state;
  logic [IW-1:0]   r_idx, w_idx, r_ptr, w_ptr;
  logic [NMST-1:0] r_gnt, w_gnt;

  logic [NMST-1:0] ar_req, aw_req, ar_pick, aw_pick;
  logic [IW-1:0]   ar_pick_idx, aw_pick_idx;
  logic            ar_any, aw_any;

  axi4_master_out_type rm, wm;  // current read / write owner's request

  assign rm = i_xmsto[r_idx];
  assign wm = i_xmsto[w_idx];

  always_comb begin
    ar_req = '0;
    aw_req = '0;
    for (int i = 0; i < NMST; i++) begin
      ar_req[i] = i_xmsto[i].ar_valid;
      aw_req[i] = i_xmsto[i].aw_valid;
    end
  end

  bus0_rr_pick #(.NMST(NMST), .RR_EN(RR_EN)) u_rpick (
    .req (ar_req),
    .ptr (r_ptr),
    .gnt (ar_pick),
    .idx (ar_pick_idx),
    .any (ar_any)
  );

  bus0_rr_pick #(.NMST(NMST), .RR_EN(RR_EN)) u_wpick (
    .req (aw_req),
    .ptr (w_ptr),
    .gnt (aw_pick),
    .idx (aw_pick_idx),
    .any (aw_any)
  );

  // Read FSM. The winner is registered in IDLE, so a master valid only
  // reaches the slave one cycle later through the registered grant.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_any) begin
          r_idx   <= ar_pick_idx;
          r_gnt   <= ar_pick;
          r_state <= R_ADDR;
        end
        R_ADDR: if (rm.ar_valid && i_xslvo.ar_ready) r_state <= R_DATA;
        R_DATA: if (i_xslvo.r_valid && rm.r_ready && i_xslvo.r_last) begin
          r_state <= R_IDLE;
          r_gnt   <= '0;
          r_ptr   <= bus0_arb_next(r_idx, NMST);
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM, same shape with an extra response phase.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_gnt   <= '0;
      w_ptr   <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_any) begin
          w_idx   <= aw_pick_idx;
          w_gnt   <= aw_pick;
          w_state <= W_ADDR;
        end
        W_ADDR: if (wm.aw_valid && i_xslvo.aw_ready) w_state <= W_DATA;
        W_DATA: if (wm.w_valid && i_xslvo.w_ready && wm.w_last) w_state <= W_RESP;
        W_RESP: if (i_xslvo.b_valid && wm.b_ready) begin
          w_state <= W_IDLE;
          w_gnt   <= '0;
          w_ptr   <= bus0_arb_next(w_idx, NMST);
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Slave-side request mux; every field is zero outside its phase.
  always_comb begin
    o_xslvi = '0;
    if (r_state == R_ADDR) begin
      o_xslvi.ar_valid = rm.ar_valid;
      o_xslvi.ar_bits  = rm.ar_bits;
      o_xslvi.ar_id    = rm.ar_id;
      o_xslvi.ar_user  = rm.ar_user;
    end
    if (r_state == R_DATA) o_xslvi.r_ready = rm.r_ready;
    if (w_state == W_ADDR) begin
      o_xslvi.aw_valid = wm.aw_valid;
      o_xslvi.aw_bits  = wm.aw_bits;
      o_xslvi.aw_id    = wm.aw_id;
      o_xslvi.aw_user  = wm.aw_user;
    end
    // W beats offered early (alongside AW) stay blocked until W_DATA.
    if (w_state == W_DATA) begin
      o_xslvi.w_valid = wm.w_valid;
      o_xslvi.w_data  = wm.w_data;
      o_xslvi.w_last  = wm.w_last;
      o_xslvi.w_strb  = wm.w_strb;
      o_xslvi.w_user  = wm.w_user;
    end
    if (w_state == W_RESP) o_xslvi.b_ready = wm.b_ready;
  end

  // Master-side response routing: the slave's ready/valid go straight to
  // the owner with no added latency; non-owners see all zeros.
  always_comb begin
    o_xmsti = '0;
    for (int i = 0; i < NMST; i++) begin
      if (r_gnt[i]) begin
        if (r_state == R_ADDR) o_xmsti[i].ar_ready = i_xslvo.ar_ready;
        if (r_state == R_DATA) begin
          o_xmsti[i].r_valid = i_xslvo.r_valid;
          o_xmsti[i].r_resp  = i_xslvo.r_resp;
          o_xmsti[i].r_data  = i_xslvo.r_data;
          o_xmsti[i].r_last  = i_xslvo.r_last;
          o_xmsti[i].r_id    = i_xslvo.r_id;
          o_xmsti[i].r_user  = i_xslvo.r_user;
        end
      end
      if (w_gnt[i]) begin
        if (w_state == W_ADDR) o_xmsti[i].aw_ready = i_xslvo.aw_ready;
        if (w_state == W_DATA) o_xmsti[i].w_ready  = i_xslvo.w_ready;
        if (w_state == W_RESP) begin
          o_xmsti[i].b_valid = i_xslvo.b_valid;
          o_xmsti[i].b_resp  = i_xslvo.b_resp;
          o_xmsti[i].b_id    = i_xslvo.b_id;
          o_xmsti[i].b_user  = i_xslvo.b_user;
        end
      end
    end
  end

  assign o_rgrant = r_gnt;
  assign o_wgrant = w_gnt;

endmodule

// File: tb/tb_bus0_xslv_arbiter.sv
// Directed bench: dut_a is round-robin, dut_b is fixed priority. Inputs are
// driven 1 time unit after the rising edge and checked a few units later.
module tb_bus0_xslv_arbiter;
  import types_bus0_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  bus0_xmst_out_vector mo_a, mo_b;
  bus0_xmst_in_vector  mi_a, mi_b;
  axi4_slave_in_type   si_a, si_b;
  axi4_slave_out_type  so_a, so_b;
  logic [1:0]          rg_a, wg_a, rg_b, wg_b;

  int n_chk = 0;
  int n_err = 0;

  bus0_xslv_arbiter #(.NMST(2), .RR_EN(1'b1)) dut_a (
    .i_clk(clk), .i_nrst(nrst), .i_xmsto(mo_a), .o_xmsti(mi_a),
    .o_xslvi(si_a), .i_xslvo(so_a), .o_rgrant(rg_a), .o_wgrant(wg_a)
  );

  bus0_xslv_arbiter #(.NMST(2), .RR_EN(1'b0)) dut_b (
    .i_clk(clk), .i_nrst(nrst), .i_xmsto(mo_b), .o_xmsti(mi_b),
    .o_xslvi(si_b), .i_xslvo(so_b), .o_rgrant(rg_b), .o_wgrant(wg_b)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Serve one read on dut_a: requests are already up and the FSM is idle.
  task automatic a_rd_serve(input int w, input int nb);
    logic [1:0] g;
    g = '0;
    g[w] = 1'b1;
    step;
    #1;
    chk("rd_grant", rg_a, g);
    chk("rd_ar_valid", si_a.ar_valid, 1);
    chk("rd_ar_addr", si_a.ar_bits.addr, mo_a[w].ar_bits.addr);
    chk("rd_ar_len", si_a.ar_bits.len, mo_a[w].ar_bits.len);
    so_a.ar_ready = 1'b1;
    #1;
    chk("rd_ar_ready_own", mi_a[w].ar_ready, 1);
    chk("rd_ar_ready_other", mi_a[1-w].ar_ready, 0);
    step;
    mo_a[w].ar_valid = 1'b0;
    mo_a[w].r_ready  = 1'b1;
    so_a.ar_ready    = 1'b0;
    so_a.r_id        = mo_a[w].ar_id;
    for (int b = 0; b < nb; b++) begin
      so_a.r_valid = 1'b1;
      so_a.r_data  = 64'(w * 16 + b);
      so_a.r_last  = (b == nb - 1);
      #1;
      chk("rd_r_valid_own", mi_a[w].r_valid, 1);
      chk("rd_r_data", mi_a[w].r_data, 64'(w * 16 + b));
      chk("rd_r_valid_other", mi_a[1-w].r_valid, 0);
      step;
    end
    so_a.r_valid = 1'b0;
    so_a.r_last  = 1'b0;
    #1;
    chk("rd_idle_grant", rg_a, 0);
  endtask

  initial begin
    mo_a = '0; mo_b = '0; so_a = '0; so_b = '0;
    repeat (2) step;
    chk("rst_rgrant", rg_a, 0);
    chk("rst_wgrant", wg_a, 0);
    chk("rst_slv_zero", (si_a == '0), 1);
    chk("rst_mst_zero", (mi_a == '0), 1);
    nrst = 1'b1;
    step;

    // Contention with pointer 0: M0 then M1.
    mo_a[0].ar_valid = 1'b1; mo_a[0].ar_bits.addr = 32'h8000_0100; mo_a[0].ar_bits.len = 8'd1;
    mo_a[1].ar_valid = 1'b1; mo_a[1].ar_bits.addr = 32'h8000_0200; mo_a[1].ar_bits.len = 8'd1;
    a_rd_serve(0, 2);
    a_rd_serve(1, 2);

    // Single read M0, len 3, with the arbitration gap visible.
    mo_a[0].ar_valid = 1'b1; mo_a[0].ar_bits.addr = 32'h8000_0000; mo_a[0].ar_bits.len = 8'd3;
    mo_a[0].ar_id = 5'd5;
    #1;
    chk("gap_ar_valid", si_a.ar_valid, 0);
    chk("gap_grant", rg_a, 0);
    a_rd_serve(0, 4);

    // Pointer now 1: the next pair goes M1 then M0.
    mo_a[0].ar_valid = 1'b1; mo_a[0].ar_bits.len = 8'd0;
    mo_a[1].ar_valid = 1'b1; mo_a[1].ar_bits.len = 8'd0;
    a_rd_serve(1, 1);
    a_rd_serve(0, 1);

    // Write M1, W presented before AW is accepted.
    mo_a = '0; so_a = '0;
    so_a.w_ready = 1'b1;
    mo_a[1].aw_valid = 1'b1; mo_a[1].aw_bits.addr = 32'h8000_1000; mo_a[1].aw_bits.len = 8'd1;
    mo_a[1].aw_id = 5'd3;
    mo_a[1].w_valid = 1'b1; mo_a[1].w_data = 64'hA0; mo_a[1].w_strb = 8'hFF;
    mo_a[1].b_ready = 1'b1; mo_a[0].b_ready = 1'b1;
    #1;
    chk("wr_idle_grant", wg_a, 0);
    chk("wr_idle_w_ready", mi_a[1].w_ready, 0);
    step;
    #1;
    chk("wr_grant", wg_a, 2'b10);
    chk("wr_aw_addr", si_a.aw_bits.addr, 32'h8000_1000);
    chk("wr_early_w_valid", si_a.w_valid, 0);
    chk("wr_early_w_ready", mi_a[1].w_ready, 0);
    so_a.aw_ready = 1'b1;
    #1;
    chk("wr_aw_ready_own", mi_a[1].aw_ready, 1);
    chk("wr_aw_ready_other", mi_a[0].aw_ready, 0);
    step;
    mo_a[1].aw_valid = 1'b0; so_a.aw_ready = 1'b0;
    #1;
    chk("wr_w0_valid", si_a.w_valid, 1);
    chk("wr_w0_data", si_a.w_data, 64'hA0);
    chk("wr_w_ready_own", mi_a[1].w_ready, 1);
    chk("wr_w_ready_other", mi_a[0].w_ready, 0);
    step;
    mo_a[1].w_data = 64'hA1; mo_a[1].w_last = 1'b1;
    #1;
    chk("wr_w1_data", si_a.w_data, 64'hA1);
    chk("wr_w1_last", si_a.w_last, 1);
    step;
    mo_a[1].w_valid = 1'b0; mo_a[1].w_last = 1'b0; so_a.w_ready = 1'b0;
    so_a.b_valid = 1'b1; so_a.b_resp = AXI_RESP_SLVERR; so_a.b_id = 5'd3;
    #1;
    chk("wr_b_valid_own", mi_a[1].b_valid, 1);
    chk("wr_b_resp", mi_a[1].b_resp, 2'b10);
    chk("wr_b_id", mi_a[1].b_id, 5'd3);
    chk("wr_b_valid_other", mi_a[0].b_valid, 0);
    chk("wr_b_ready_slv", si_a.b_ready, 1);
    step;
    so_a.b_valid = 1'b0;
    #1;
    chk("wr_done_grant", wg_a, 0);

    // Concurrent read M0 / write M1, ready raised on non-owners too.
    mo_a = '0; so_a = '0;
    mo_a[0].ar_valid = 1'b1; mo_a[0].ar_bits.addr = 32'h8000_2000; mo_a[0].ar_bits.len = 8'd1;
    mo_a[1].aw_valid = 1'b1; mo_a[1].aw_bits.addr = 32'h8000_3000;
    mo_a[1].w_valid = 1'b1; mo_a[1].w_last = 1'b1; mo_a[1].w_data = 64'hB0;
    mo_a[0].r_ready = 1'b1; mo_a[1].r_ready = 1'b1;
    mo_a[0].b_ready = 1'b1; mo_a[1].b_ready = 1'b1;
    step;
    #1;
    chk("cc_rgrant", rg_a, 2'b01);
    chk("cc_wgrant", wg_a, 2'b10);
    so_a.ar_ready = 1'b1; so_a.aw_ready = 1'b1;
    step;
    mo_a[0].ar_valid = 1'b0; mo_a[1].aw_valid = 1'b0;
    so_a.ar_ready = 1'b0; so_a.aw_ready = 1'b0;
    so_a.r_valid = 1'b1; so_a.r_data = 64'hC0; so_a.w_ready = 1'b1;
    #1;
    chk("cc_r_own", mi_a[0].r_valid, 1);
    chk("cc_r_other", mi_a[1].r_valid, 0);
    chk("cc_w_data", si_a.w_data, 64'hB0);
    chk("cc_w_ready_own", mi_a[1].w_ready, 1);
    chk("cc_w_ready_other", mi_a[0].w_ready, 0);
    step;
    mo_a[1].w_valid = 1'b0; so_a.w_ready = 1'b0;
    so_a.r_data = 64'hC1; so_a.r_last = 1'b1;
    so_a.b_valid = 1'b1; so_a.b_resp = AXI_RESP_OKAY;
    #1;
    chk("cc_b_own", mi_a[1].b_valid, 1);
    chk("cc_b_other", mi_a[0].b_valid, 0);
    chk("cc_r1_data", mi_a[0].r_data, 64'hC1);
    chk("cc_r1_other", mi_a[1].r_valid, 0);
    step;
    so_a.r_valid = 1'b0; so_a.r_last = 1'b0; so_a.b_valid = 1'b0;
    #1;
    chk("cc_done_rgrant", rg_a, 0);
    chk("cc_done_wgrant", wg_a, 0);

    // Fixed priority: M0 re-requests every time, M1 never wins.
    mo_b[0].ar_valid = 1'b1; mo_b[0].ar_bits.addr = 32'h8000_4000;
    mo_b[1].ar_valid = 1'b1; mo_b[1].ar_bits.addr = 32'h8000_5000;
    mo_b[0].r_ready = 1'b1; mo_b[1].r_ready = 1'b1;
    so_b.ar_ready = 1'b1; so_b.r_valid = 1'b1; so_b.r_last = 1'b1;
    for (int t = 0; t < 10; t++) begin
      step;
      #1;
      chk("fp_grant", rg_b, 2'b01);
      chk("fp_ar_addr", si_b.ar_bits.addr, 32'h8000_4000);
      step;
      #1;
      chk("fp_r_own", mi_b[0].r_valid, 1);
      chk("fp_r_other", mi_b[1].r_valid, 0);
      step;
    end
    mo_b = '0; so_b = '0;

    // Reset during beat 2 of a 4-beat read.
    mo_a = '0; so_a = '0;
    mo_a[0].ar_valid = 1'b1; mo_a[0].ar_bits.addr = 32'h8000_0000; mo_a[0].ar_bits.len = 8'd3;
    mo_a[0].r_ready = 1'b1;
    step;
    so_a.ar_ready = 1'b1;
    step;
    mo_a[0].ar_valid = 1'b0; so_a.ar_ready = 1'b0;
    so_a.r_valid = 1'b1; so_a.r_data = 64'h1;
    step;
    so_a.r_data = 64'h2;
    #1;
    chk("mid_r_valid", mi_a[0].r_valid, 1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_grant", rg_a, 0);
    chk("mid_rst_slv_zero", (si_a == '0), 1);
    chk("mid_rst_mst_zero", (mi_a == '0), 1);
    mo_a = '0; so_a = '0;
    step;
    step;
    nrst = 1'b1;
    step;
    mo_a[1].ar_valid = 1'b1; mo_a[1].ar_bits.addr = 32'h8000_6000; mo_a[1].ar_bits.len = 8'd0;
    a_rd_serve(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Backstop against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
